// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int XLEN     = 32;
  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 7;

  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPCODE_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer with push/pop/clear and count. With REG_HEAD the head is
// presented from a register that tracks the post-update head entry.
module fetch_queue_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int W        = $bits(fetch_entry_t),
  parameter bit REG_HEAD = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_nxt;
  logic [AW:0]   count_q;
  logic          push_en, pop_en;

  assign pop_en     = pop_i && (count_q != '0);
  assign push_en    = push_i && ((count_q != FULL) || pop_en);
  assign rd_ptr_nxt = rd_ptr_q + AW'(pop_en);
  assign count_o    = count_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_nxt;
      wr_ptr_q <= wr_ptr_q + AW'(push_en);
      count_q  <= count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en && !clr_i) mem[wr_ptr_q] <= din_i;
  end

  if (REG_HEAD) begin : g_reg_head
    logic [W-1:0] head_nxt, head_p1;

    // The incoming word becomes the head when nothing older survives this cycle.
    always_comb begin
      head_nxt = mem[rd_ptr_nxt];
      if (push_en && (count_q == (AW+1)'(pop_en))) head_nxt = din_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)    head_p1 <= '0;
      else if (!clr_i) head_p1 <= head_nxt;
    end

    assign head_o = head_p1;
  end else begin : g_comb_head
    assign head_o = mem[rd_ptr_q];
  end

endmodule

// File: rtl/fetch_queue.sv
// Sequential instruction fetcher feeding decode through a credit-limited queue.
// Define FETCH_QUEUE_BYPASS_EN to present a response to decode in its arrival cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   redirect_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  output logic                   imem_req_o,
  output logic [XLEN-1:0]        imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_W-1:0]     imem_rdata_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [INSTR_W-1:0]     instr_o,
  output logic [XLEN-1:0]        instr_pc_o,
  output logic [OPCODE_W-1:0]    op_o,
  output logic [$clog2(DEPTH):0] occupancy_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            run_q, redir, credit_ok, gnt_fire, rsp_live, rsp_keep;
  logic            q_push, q_pop, q_nonempty;
  logic [XLEN-1:0] fetch_pc_q, oldest_pc;
  logic [CW-1:0]   occ, in_flight, discard_q;
  fetch_entry_t    push_ent, head_ent;

  // A redirect in the cycle reset releases is ignored.
  assign redir      = redirect_i & run_q;
  assign credit_ok  = ({1'b0, occ} + {1'b0, in_flight}) < (CW+1)'(DEPTH);
  assign imem_req_o = run_q & ~redirect_i & credit_ok;
  assign gnt_fire   = imem_req_o & imem_gnt_i;
  assign rsp_live   = imem_rvalid_i & run_q;
  assign rsp_keep   = rsp_live & (discard_q == '0) & ~redir;
  assign q_nonempty = (occ != '0);
  assign q_pop      = q_nonempty & ~redir & instr_ready_i;
  assign push_ent   = '{instr: imem_rdata_i, pc: oldest_pc};

  assign imem_addr_o = fetch_pc_q;
  assign occupancy_o = occ;
  assign op_o        = instr_valid_o ? opcode_of(instr_o) : '0;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;

  assign byp           = rsp_keep & ~q_nonempty;
  assign instr_valid_o = byp | (q_nonempty & ~redir);
  assign instr_o       = byp ? imem_rdata_i : head_ent.instr;
  assign instr_pc_o    = byp ? oldest_pc : head_ent.pc;
  assign q_push        = rsp_keep & ~(byp & instr_ready_i);
`else
  assign instr_valid_o = q_nonempty & ~redir;
  assign instr_o       = head_ent.instr;
  assign instr_pc_o    = head_ent.pc;
  assign q_push        = rsp_keep;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      run_q <= 1'b1;
      if (redir)         fetch_pc_q <= redirect_pc_i;
      else if (gnt_fire) fetch_pc_q <= fetch_pc_q + PC_INCR;
      // Everything still outstanding after this edge belongs to the old path.
      if (redir)
        discard_q <= in_flight + CW'(gnt_fire) - CW'(rsp_live);
      else if (rsp_live && (discard_q != '0))
        discard_q <= discard_q - CW'(1);
    end
  end

  fetch_queue_fifo #(
    .DEPTH   (DEPTH),
    .W       (XLEN),
    .REG_HEAD(1'b0)
  ) u_pc_fifo (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (1'b0),
    .push_i (gnt_fire),
    .din_i  (fetch_pc_q),
    .pop_i  (rsp_live),
    .head_o (oldest_pc),
    .count_o(in_flight)
  );

  fetch_queue_fifo #(
    .DEPTH   (DEPTH),
    .W       ($bits(fetch_entry_t)),
    .REG_HEAD(1'b1)
  ) u_entry_fifo (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (redir),
    .push_i (q_push),
    .din_i  (push_ent),
    .pop_i  (q_pop),
    .head_o (head_ent),
    .count_o(occ)
  );

endmodule
